seg7_scan_reader: RTL and testbench

//   Receive side of the active-low 7-segment display interface. Watches a

---
 rtl/seg7_pkg.sv | 21 ++
 rtl/seg7_glyph_decode.sv | 26 ++
 rtl/seg7_scan_reader.sv | 166 ++++++++++++++++
 tb/tb_seg7_scan_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment glyph table and scan-reader FSM encoding
// Purpose: glyph constants (active-high gfedcba) shared by the segment decoder
//   and the scan reader, the blank pattern, and the reader FSM state type.
// Ports: none (package).
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h00;

  // Index = hex value; exactly one legal form per digit.
  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational 7-segment glyph to hex decoder
// Purpose: map an active-high segment pattern back to its hex value.
// Ports:
//   seg  in  7  segments, active-high, bit0=a .. bit6=g
//   ok   out 1  pattern is one of the 16 legal glyphs
//   hex  out 4  decoded value (0 when not ok)
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       ok,
  output logic [3:0] hex
);

  always_comb begin
    ok  = 1'b0;
    hex = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg != SEG7_BLANK && seg == SEG7_GLYPH[i]) begin
        ok  = 1'b1;
        hex = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - reconstructs digits from a multiplexed 7-segment bus
// Purpose: watch an active-low multiplexed display bus and capture the glyph
//   shown on each digit once it has been stable long enough.
// Ports:
//   clk         in  1          system clock, rising edge
//   rst_n       in  1          asynchronous active-low reset
//   an_n        in  DIGITS     digit enables, active-low
//   seg_n       in  7          segments a..g, active-low
//   dp_n        in  1          decimal point, active-low
//   digit_val   out 4*DIGITS   captured hex value per digit
//   digit_dp    out DIGITS     captured dp (1 = lit) per digit
//   digit_vld   out DIGITS     digit captured at least once since reset
//   digit_err   out DIGITS     last capture of the digit was not a legal glyph
//   frame_done  out 1          pulse when every digit has been captured
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  input  logic                  dp_n,
  output logic [4*DIGITS-1:0]   digit_val,
  output logic [DIGITS-1:0]     digit_dp,
  output logic [DIGITS-1:0]     digit_vld,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BUS_W = DIGITS + 8;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W:0]   CNT_TARGET = (CNT_W + 1)'(STABLE_CYCLES);

  logic [BUS_W-1:0]  sync1, snap, prev;
  logic [DIGITS-1:0] an_act, an_low;
  logic [6:0]        seg_act;
  logic              dp_lit, one_hot, changed;
  logic [IDX_W-1:0]  idx;
  logic              dec_ok;
  logic [3:0]        dec_hex;

  seg7_state_e       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W:0]    cnt_inc;
  logic              capture;

  logic [DIGITS-1:0] seen, seen_nxt, cap_mask;

  // Idle bus is all ones, so the synchroniser resets to "no digit driven".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      snap  <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {an_n, seg_n, dp_n};
      snap  <= sync1;
      prev  <= snap;
    end
  end

  assign an_act  = ~snap[BUS_W-1:8];
  assign seg_act = ~snap[7:1];
  assign dp_lit  = ~snap[0];
  assign changed = (snap != prev);

  // Clearing the lowest set bit leaves zero only for a single active anode.
  assign an_low  = an_act & (an_act - DIGITS'(1));
  assign one_hot = (|an_act) && !(|an_low);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_act[i]) idx = IDX_W'(i);
    end
  end

  seg7_glyph_decode u_decode (
    .seg (seg_act),
    .ok  (dec_ok),
    .hex (dec_hex)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign cnt_inc = {1'b0, cnt} + (CNT_W + 1)'(1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!one_hot) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_W'(1);
        end
        SETTLE: begin
          if (changed) begin
            cnt_nxt = CNT_W'(1);
          end else if (cnt_inc >= CNT_TARGET) begin
            // Counter parks at its maximum; it never wraps.
            capture   = 1'b1;
            cnt_nxt   = CNT_MAX;
            state_nxt = HOLD;
          end else begin
            cnt_nxt = cnt_inc[CNT_W-1:0];
          end
        end
        HOLD: begin
          if (changed) begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cap_mask = capture ? (DIGITS'(1) << idx) : '0;
  assign seen_nxt = seen | cap_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_val  <= '0;
      digit_dp   <= '0;
      digit_vld  <= '0;
      digit_err  <= '0;
      seen       <= '0;
      frame_done <= 1'b0;
    end else begin
      if (capture) begin
        digit_vld[idx] <= 1'b1;
        digit_dp[idx]  <= dp_lit;
        digit_err[idx] <= ~dec_ok;
        if (dec_ok) digit_val[int'(idx)*4 +: 4] <= dec_hex;
      end
      // The completing capture raises the pulse in the same edge; seen then
      // restarts empty so a capture on the pulse cycle opens the next frame.
      if (seen_nxt == '1) begin
        seen       <= '0;
        frame_done <= 1'b1;
      end else begin
        seen       <= seen_nxt;
        frame_done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb/tb_seg7_scan_reader.sv - scoreboard bench for seg7_scan_reader
module tb_seg7_scan_reader;

  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [15:0] digit_val;
  logic [3:0]  digit_dp, digit_vld, digit_err;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .digit_val  (digit_val),
    .digit_dp   (digit_dp),
    .digit_vld  (digit_vld),
    .digit_err  (digit_err),
    .frame_done (frame_done)
  );

  logic [6:0] glyph_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int          due;
    logic [15:0] val;
    logic [3:0]  dp, vld, err;
    bit          frame;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int frame_pulses = 0;

  logic [15:0] m_val;
  logic [3:0]  m_dp, m_vld, m_err, m_seen;
  logic [11:0] cur_bus;
  int          run_start, run_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input int h);
    logic [6:0] g;
    g = glyph_tab[h];
    return ~g;
  endfunction

  task automatic model_reset();
    q.delete();
    m_val = '0; m_dp = '0; m_vld = '0; m_err = '0; m_seen = '0;
    cur_bus = '1;
    run_len = 1000;
    run_start = 0;
  endtask

  // A value held for S consecutive edges with exactly one anode lit is
  // captured; it lands on the outputs S+1 edges after its first edge.
  task automatic model_capture();
    logic [3:0] act;
    logic [6:0] g;
    int d;
    bit found;
    int h;
    exp_t e;
    act = ~cur_bus[11:8];
    if ($countones(act) != 1) return;
    d = 0;
    for (int i = 0; i < 4; i++) if (act[i]) d = i;
    g = ~cur_bus[7:1];
    found = 0; h = 0;
    for (int i = 0; i < 16; i++) if (glyph_tab[i] == g) begin found = 1; h = i; end
    m_vld[d] = 1'b1;
    m_dp[d]  = ~cur_bus[0];
    m_err[d] = !found;
    if (found) m_val[d*4 +: 4] = 4'(h);
    m_seen[d] = 1'b1;
    e.frame = (m_seen == 4'hF);
    if (e.frame) m_seen = '0;
    e.due = run_start + 1 + S;
    e.val = m_val; e.dp = m_dp; e.vld = m_vld; e.err = m_err;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    logic [11:0] bus;
    @(negedge clk);
    an_n = an; seg_n = seg; dp_n = dp;
    bus = {an, seg, dp};
    if (bus == cur_bus) run_len++;
    else begin
      cur_bus = bus;
      run_start = cyc + 1;
      run_len = 1;
    end
    if (run_len == S) model_capture();
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
    repeat (n) drive(an, seg, dp);
  endtask

  task automatic idle(input int n);
    hold(4'hF, 7'h7F, 1'b1, n);
  endtask

  // Monitor: pops the scoreboard when a capture is due and otherwise
  // requires the outputs to hold their last expected image.
  exp_t        mon_e;
  logic [15:0] mon_val = '0;
  logic [3:0]  mon_dp = '0, mon_vld = '0, mon_err = '0;
  bit          mon_fr;

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      check("reset_outputs", {3'b0, digit_val, digit_dp, digit_vld, digit_err, frame_done}, 32'h0);
      mon_val = '0; mon_dp = '0; mon_vld = '0; mon_err = '0;
    end else begin
      mon_fr = 0;
      while (q.size() > 0 && q[0].due < cyc) begin
        tests++; fails++;
        $display("FAIL capture_overdue: due %0d now %0d", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        mon_val = mon_e.val; mon_dp = mon_e.dp; mon_vld = mon_e.vld; mon_err = mon_e.err;
        mon_fr = mon_e.frame;
      end
      check("outputs", {4'b0, digit_val, digit_dp, digit_vld, digit_err},
                       {4'b0, mon_val, mon_dp, mon_vld, mon_err});
      check("frame_done", 32'(frame_done), 32'(mon_fr));
      if (frame_done) frame_pulses++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [3:0] an;
    logic [6:0] sg;
    rst_n = 1'b0; an_n = '1; seg_n = '1; dp_n = 1'b1;
    model_reset();
    repeat (6) begin
      @(negedge clk);
      an_n = 4'($urandom); seg_n = 7'($urandom); dp_n = 1'($urandom);
    end
    @(negedge clk);
    an_n = '1; seg_n = '1; dp_n = 1'b1; rst_n = 1'b1;
    idle(20);
    check("idle_vld", 32'(digit_vld), 32'h0);

    // Static digit 0 showing 5
    hold(4'b1110, 7'h12, 1'b1, 10);
    check("static_val", 32'(digit_val[3:0]), 32'h5);
    check("static_vld", 32'(digit_vld), 32'h1);
    check("static_err", 32'(digit_err), 32'h0);

    // Scan 1, A, b, F with dp on digit 2
    p0 = frame_pulses;
    hold(4'b1110, seg_of(1),  1'b1, 8);
    hold(4'b1101, seg_of(10), 1'b1, 8);
    hold(4'b1011, seg_of(11), 1'b0, 8);
    hold(4'b0111, seg_of(15), 1'b1, 8);
    idle(3);
    check("scan_val", 32'(digit_val), 32'hFBA1);
    check("scan_dp", 32'(digit_dp), 32'h4);
    check("scan_frames", 32'(frame_pulses - p0), 32'h1);

    // Glitching digit 1: never stable long enough
    repeat (6) begin
      drive(4'b1101, seg_of(3), 1'b1);
      drive(4'b1101, seg_of(3) ^ 7'h01, 1'b1);
      drive(4'b1101, seg_of(3) ^ 7'h01, 1'b1);
    end
    idle(4);
    check("glitch_val", 32'(digit_val), 32'hFBA1);

    // Blank and illegal glyph on digit 3, then ghosting on two anodes
    hold(4'b0111, 7'h7F, 1'b1, 8);
    check("blank_err", 32'(digit_err[3]), 32'h1);
    check("blank_val", 32'(digit_val[15:12]), 32'hF);
    hold(4'b0111, ~7'h40, 1'b1, 8);
    check("illegal_err", 32'(digit_err[3]), 32'h1);
    hold(4'b1100, seg_of(8), 1'b0, 8);
    check("ghost_val", 32'(digit_val), 32'hFBA1);

    // Randomised runs
    repeat (80) begin
      if ($urandom_range(0, 3) == 0) an = 4'($urandom);
      else an = ~(4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sg = 7'($urandom);
      else sg = seg_of(int'($urandom_range(0, 15)));
      hold(an, sg, 1'($urandom), int'($urandom_range(1, 9)));
    end
    idle(8);

    // Asynchronous reset in the middle of settling
    hold(4'b1011, seg_of(7), 1'b1, 4);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {3'b0, digit_val, digit_dp, digit_vld, digit_err, frame_done}, 32'h0);
    @(negedge clk);
    an_n = '1; seg_n = '1; dp_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("post_reset_vld", 32'(digit_vld), 32'h0);

    hold(4'b1110, seg_of(2), 1'b0, 8);
    idle(6);
    check("post_reset_val", 32'(digit_val), 32'h2);
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
